calculation_unit_normalize_round: RTL and testbench
===================================================

CALCULATION_UNIT_NORMALIZE_ROUND -- requirements
Module: calculation_unit_normalize_round

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have: in_valid  input  1  input beat present; in_ready  output  1  block accepts beat.
REQ-003 SHALL have: in_sign  input  1  result sign; in_exponent  input  10  two's-complement biased exponent (bias 127) of the raw sum.
REQ-004 SHALL have: in_fraction  input  49  raw adder sum, [xx.47] format (2 integer bits, 47 fractional bits).
REQ-005 SHALL have: in_rounding_mode  input  3  0=RNE, 1=RTZ, 2=RDN, 3=RUP, 4=RMM; other codes are treated as RNE.
REQ-006 SHALL have: out_valid  output  1  result present; out_ready  input  1  consumer accepts.
REQ-007 SHALL have: out_result  output  32  IEEE-754 single; out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-008 SHALL be a 2-stage pipeline.
- S1: leading-one detect and normalizing shift.
- S2: round, exponent adjust and pack.
- Latency: 2 cycles from accepted beat to out_valid with out_ready held high.
REQ-009 Handshake:
- A beat transfers when valid && ready.
- in_ready = !s1_valid || s1_advance.
- s1_advance = !s2_valid || out_ready.
- Full throughput of 1 beat/cycle when out_ready is held high.
REQ-010 While out_valid && !out_ready, out_result and out_flags SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-011 If in_fraction[48]=1: shift right by 1, exponent+1, and OR the dropped bit into sticky.
REQ-012 Else: shift left by the leading-zero count of bits [47:0], and subtract the count from the exponent.
REQ-013 Rounding bits after normalization:
- 24-bit significand (hidden bit plus 23 bits).
- Guard = next bit.
- Sticky = OR of all remaining bits.
- inexact = guard | sticky.
REQ-014 Rounding rules:
- RNE: increment if guard && (sticky || lsb).
- RTZ: never increment.
- RDN: increment if inexact && sign.
- RUP: increment if inexact && !sign.
- RMM: increment if guard.
REQ-015 Rounding carry-out SHALL renormalize: significand becomes 1.0 and the exponent is incremented.
REQ-016 Zero in_fraction SHALL produce signed zero {in_sign, 31'd0}, with flags 0.
REQ-017 Overflow (final exponent >= 255):
- Set overflow and inexact.
- Result is infinity for RNE, RMM, and for RUP with a positive sign or RDN with a negative sign.
- Otherwise the result is max finite 0x7F7FFFFF with the sign applied.
REQ-018 Underflow (final exponent <= 0) SHALL follow REQ-024/REQ-025.
REQ-019 Simultaneous input acceptance and output drain in one cycle SHALL both occur with no bubble.

Reset
REQ-020 On reset_n low, asynchronously clear both stage valid bits.
REQ-021 Reset values: out_valid=0, out_result=0, out_flags=0, in_ready=1 once reset is deasserted.
REQ-022 Reset mid-operation SHALL discard all in-flight beats; the first post-reset beat SHALL behave as from idle.
REQ-023 Datapath registers other than valid bits and outputs need no reset.

Configuration
REQ-024 With macro NORMALIZE_ROUND_SUBNORMAL_EN defined:
- Underflowing results are denormalized: shift right by (1 - exponent), with shifted-out bits ORed into sticky, then rounded per REQ-014.
- Exponent field = 0, unless rounding carries into the hidden bit, giving exponent 1.
- underflow is set when the result is tiny and inexact.
REQ-025 Without NORMALIZE_ROUND_SUBNORMAL_EN, an underflowing result SHALL flush to signed zero, with underflow=1 and inexact=1.

Structure
REQ-026 Shared package calculation_unit_pkg SHALL hold:
- rounding_mode_t enum.
- Packed struct fpu_flags_t {overflow, underflow, inexact}.
- Constants EXP_BIAS=127, EXP_MAX=255, FRAC_WIDTH=23.
REQ-027 The leading-zero count over 48 bits SHALL be the sub-module calculation_unit_leading_zero_counter (6-bit count output, all-zero flag).

Verification
REQ-028 Bench SHALL drive in_fraction bit48 only, exponent 127, sign 0, RNE -> out_result 0x40000000, flags 000, exactly 2 cycles later.
REQ-029 Bench SHALL drive in_fraction bit47 only, exponent 127 -> 0x3F800000; then in_fraction=0 with sign 1 -> 0x80000000, flags 000.
REQ-030 Bench SHALL drive bits [47:24] all ones plus bit 23, exponent 127:
- RNE -> 0x40000000, inexact=1.
- RTZ -> 0x3FFFFFFF, inexact=1.
REQ-031 Bench SHALL drive bit47, exponent 255:
- RNE -> 0x7F800000, flags 101.
- RTZ -> 0x7F7FFFFF, flags 101.
REQ-032 Bench SHALL drive bit47, exponent 0, RNE:
- With macro -> 0x00400000, flags 000.
- Without macro -> 0x00000000, flags 011.
REQ-033 Bench SHALL stream 4 back-to-back beats with out_ready low for 3 cycles mid-stream:
- in_ready drops once both stages are full.
- Outputs hold stable while stalled.
- All 4 results arrive in order with no loss or duplication.
- A reset_n pulse mid-stream yields out_valid=0 immediately.

Source files
------------

// File: rtl/calculation_unit_pkg.sv
// Shared types and helpers for the calculation unit back end: rounding-mode
// encoding, the exception-flag bundle, exponent constants and the rounding
// decision functions used by the normalize/round pipeline.
package calculation_unit_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_MAX    = 255;
    localparam int FRAC_WIDTH = 23;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rounding_mode_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    // Unknown mode codes fall back to round-to-nearest-even.
    function automatic rounding_mode_t decode_rounding_mode(input logic [2:0] code);
        rounding_mode_t rm;
        case (code)
            3'd1:    rm = RM_RTZ;
            3'd2:    rm = RM_RDN;
            3'd3:    rm = RM_RUP;
            3'd4:    rm = RM_RMM;
            default: rm = RM_RNE;
        endcase
        return rm;
    endfunction

    // Decide whether the truncated significand must be bumped by one ulp.
    function automatic logic round_increment(input rounding_mode_t rm, input logic sign,
                                             input logic lsb, input logic guard,
                                             input logic sticky);
        logic inc;
        case (rm)
            RM_RNE:  inc = guard && (sticky || lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (guard || sticky) && sign;
            RM_RUP:  inc = (guard || sticky) && !sign;
            RM_RMM:  inc = guard;
            default: inc = guard && (sticky || lsb);
        endcase
        return inc;
    endfunction

    // On overflow, modes that round away from zero in the sign's direction saturate to infinity.
    function automatic logic overflow_to_infinity(input rounding_mode_t rm, input logic sign);
        logic to_inf;
        case (rm)
            RM_RNE:  to_inf = 1'b1;
            RM_RMM:  to_inf = 1'b1;
            RM_RUP:  to_inf = !sign;
            RM_RDN:  to_inf = sign;
            default: to_inf = 1'b0;
        endcase
        return to_inf;
    endfunction

endpackage

// File: rtl/calculation_unit_leading_zero_counter.sv
// Leading-zero counter over a 48-bit word. count is 48 and all_zero is set
// when no bit is set.
module calculation_unit_leading_zero_counter
    import calculation_unit_pkg::*;
(
    input  logic [47:0] data_in,
    output logic [5:0]  count,
    output logic        all_zero
);

    // Scan from the MSB and capture the distance to the first set bit.
    always_comb begin
        count    = 6'd48;
        all_zero = 1'b1;
        for (int i = 47; i >= 0; i--) begin
            if (all_zero && data_in[i]) begin
                count    = 6'(47 - i);
                all_zero = 1'b0;
            end else begin
                all_zero = all_zero;
            end
        end
    end

endmodule

// File: rtl/calculation_unit_normalize_round.sv
// Two-stage normalize-and-round back end producing an IEEE-754 single.
// S1 normalizes the raw [xx.47] sum so the leading one sits in the hidden-bit
// position (only the 47 bits below it are kept). S2 rounds, adjusts the
// exponent, handles overflow/underflow and packs into the output register.
// Optional feature macro: NORMALIZE_ROUND_SUBNORMAL_EN -- when defined,
// underflowing results are denormalized and rounded; otherwise they flush to
// signed zero with underflow and inexact set.
module calculation_unit_normalize_round
    import calculation_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exponent,
    input  logic [48:0] in_fraction,
    input  logic [2:0]  in_rounding_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    localparam logic signed [11:0] EXP_LIMIT = 12'(EXP_MAX);

    logic [5:0]         lz_count;
    logic               lz_all_zero;
    logic               s1_advance;
    logic               s1_load;
    logic signed [11:0] in_exp_ext;

    logic               s1_valid_d,  s1_valid_q;
    logic               s1_sign_d,   s1_sign_q;
    logic signed [11:0] s1_exp_d,    s1_exp_q;
    logic [46:0]        s1_frac_d,   s1_frac_q;
    logic               s1_sticky_d, s1_sticky_q;
    logic               s1_zero_d,   s1_zero_q;
    rounding_mode_t     s1_rm_d,     s1_rm_q;

    logic               out_valid_d,  out_valid_q;
    logic [31:0]        out_result_d, out_result_q;
    fpu_flags_t         out_flags_d,  out_flags_q;

    logic               nrm_sticky;
    logic               nrm_inc;
    logic               nrm_inexact;
    logic [23:0]        nrm_sum;
    logic signed [11:0] nrm_exp;
    logic [31:0]        rnd_result;
    fpu_flags_t         rnd_flags;
`ifdef NORMALIZE_ROUND_SUBNORMAL_EN
    logic signed [11:0] sub_shift;
    logic [6:0]         sub_amt;
    logic [95:0]        sub_ext;
    logic               sub_sticky;
    logic               sub_inc;
    logic               sub_inexact;
    logic [23:0]        sub_sum;
`endif

    calculation_unit_leading_zero_counter u_lzc (
        .data_in  (in_fraction[47:0]),
        .count    (lz_count),
        .all_zero (lz_all_zero)
    );

    // Flow control: S1 moves on whenever the output register is empty or draining.
    always_comb begin
        s1_advance = !out_valid_q || out_ready;
        in_ready   = !s1_valid_q || s1_advance;
        s1_load    = in_valid && in_ready;
    end

    // Valid-bit progression through the two stages.
    always_comb begin
        if (in_ready) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_advance) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // S1: normalize so the leading one lands in the hidden-bit position.
    always_comb begin
        in_exp_ext = {{2{in_exponent[9]}}, in_exponent};
        if (s1_load) begin
            s1_sign_d = in_sign;
            s1_rm_d   = decode_rounding_mode(in_rounding_mode);
            s1_zero_d = !in_fraction[48] && lz_all_zero;
            if (in_fraction[48]) begin
                s1_frac_d   = in_fraction[47:1];
                s1_sticky_d = in_fraction[0];
                s1_exp_d    = in_exp_ext + 12'sd1;
            end else begin
                s1_frac_d   = in_fraction[46:0] << lz_count;
                s1_sticky_d = 1'b0;
                s1_exp_d    = in_exp_ext - $signed({6'd0, lz_count});
            end
        end else begin
            s1_sign_d   = s1_sign_q;
            s1_rm_d     = s1_rm_q;
            s1_zero_d   = s1_zero_q;
            s1_frac_d   = s1_frac_q;
            s1_sticky_d = s1_sticky_q;
            s1_exp_d    = s1_exp_q;
        end
    end

    // S2: round, renormalize on carry-out, classify and pack the result.
    always_comb begin
        nrm_sticky  = (|s1_frac_q[22:0]) | s1_sticky_q;
        nrm_inexact = s1_frac_q[23] | nrm_sticky;
        nrm_inc     = round_increment(s1_rm_q, s1_sign_q, s1_frac_q[24], s1_frac_q[23], nrm_sticky);
        // A carry into bit 23 means the significand rolled over to 2.0: fraction is already zero.
        nrm_sum     = {1'b0, s1_frac_q[46:24]} + {23'd0, nrm_inc};
        nrm_exp     = s1_exp_q + $signed({11'd0, nrm_sum[23]});
`ifdef NORMALIZE_ROUND_SUBNORMAL_EN
        sub_shift   = 12'sd1 - s1_exp_q;
        sub_amt     = (sub_shift > 12'sd49) ? 7'd49 : sub_shift[6:0];
        sub_ext     = {1'b1, s1_frac_q, 48'd0} >> sub_amt;
        sub_sticky  = (|sub_ext[70:0]) | s1_sticky_q;
        sub_inexact = sub_ext[71] | sub_sticky;
        sub_inc     = round_increment(s1_rm_q, s1_sign_q, sub_ext[72], sub_ext[71], sub_sticky);
        // A carry into bit 23 lifts the exponent field to 1 without extra handling.
        sub_sum     = sub_ext[95:72] + {23'd0, sub_inc};
`endif
        rnd_result  = 32'd0;
        rnd_flags   = fpu_flags_t'(3'b000);
        if (s1_zero_q) begin
            rnd_result = {s1_sign_q, 31'd0};
            rnd_flags  = fpu_flags_t'(3'b000);
        end else if (s1_exp_q <= 12'sd0) begin
`ifdef NORMALIZE_ROUND_SUBNORMAL_EN
            rnd_result          = {s1_sign_q, 7'd0, sub_sum};
            rnd_flags.overflow  = 1'b0;
            rnd_flags.underflow = sub_inexact;
            rnd_flags.inexact   = sub_inexact;
`else
            rnd_result = {s1_sign_q, 31'd0};
            rnd_flags  = fpu_flags_t'(3'b011);
`endif
        end else if (nrm_exp >= EXP_LIMIT) begin
            if (overflow_to_infinity(s1_rm_q, s1_sign_q)) begin
                rnd_result = {s1_sign_q, 8'(EXP_MAX), {FRAC_WIDTH{1'b0}}};
            end else begin
                rnd_result = {s1_sign_q, 8'(EXP_MAX - 1), {FRAC_WIDTH{1'b1}}};
            end
            rnd_flags = fpu_flags_t'(3'b101);
        end else begin
            rnd_result          = {s1_sign_q, nrm_exp[7:0], nrm_sum[FRAC_WIDTH-1:0]};
            rnd_flags.overflow  = 1'b0;
            rnd_flags.underflow = 1'b0;
            rnd_flags.inexact   = nrm_inexact;
        end
    end

    // Output register loads only when S1 hands over a beat; it holds while stalled.
    always_comb begin
        if (s1_advance && s1_valid_q) begin
            out_result_d = rnd_result;
            out_flags_d  = rnd_flags;
        end else begin
            out_result_d = out_result_q;
            out_flags_d  = out_flags_q;
        end
    end

    // Control and output state, cleared asynchronously so in-flight beats are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_flags_q  <= fpu_flags_t'(3'b000);
        end else begin
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    // S1 datapath registers; their contents are qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        s1_sign_q   <= s1_sign_d;
        s1_exp_q    <= s1_exp_d;
        s1_frac_q   <= s1_frac_d;
        s1_sticky_q <= s1_sticky_d;
        s1_zero_q   <= s1_zero_d;
        s1_rm_q     <= s1_rm_d;
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_calculation_unit_normalize_round.sv
// Self-checking bench for calculation_unit_normalize_round: directed corner
// vectors, a stalled back-to-back stream, randomized traffic against an
// arithmetic reference model, and reset in the middle of a stream.
`timescale 1ns/1ps
module tb_calculation_unit_normalize_round;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exponent;
    logic [48:0] in_fraction;
    logic [2:0]  in_rounding_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] sb_q[$];

    always #5 clk = ~clk;

    calculation_unit_normalize_round dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_sign          (in_sign),
        .in_exponent      (in_exponent),
        .in_fraction      (in_fraction),
        .in_rounding_mode (in_rounding_mode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_flags        (out_flags)
    );

    // Reference: value = f * 2^(e-127-47); round to the single-precision quantum.
    // Returns {flags[2:0], result[31:0]}.
    function automatic logic [34:0] ref_model(input logic s, input logic [9:0] e,
                                              input logic [48:0] f, input logic [2:0] rm_code);
        logic [127:0] x, sig, rem, half;
        int p, be, sh, rm;
        logic g, st, inx, inc, to_inf;
        rm = (rm_code > 3'd4) ? 0 : int'(rm_code);
        if (f == 49'd0) return {3'b000, s, 31'd0};
        p = 0;
        for (int i = 0; i < 49; i++) if (f[i]) p = i;
        be = int'($signed(e)) + p - 47;
        x  = 128'(f) << 60;
        sh = p + 60 - 23;
        if (be < 1) begin
`ifdef NORMALIZE_ROUND_SUBNORMAL_EN
            sh = sh + (1 - be);
`else
            return {3'b011, s, 31'd0};
`endif
        end
        if (sh >= 120) begin
            sig = 128'd0; g = 1'b0; st = 1'b1;
        end else begin
            sig  = x >> sh;
            rem  = x - (sig << sh);
            half = 128'd1 << (sh - 1);
            g    = (rem >= half);
            st   = g ? (rem != half) : (rem != 128'd0);
        end
        inx = g | st;
        case (rm)
            0:       inc = g & (st | sig[0]);
            1:       inc = 1'b0;
            2:       inc = inx & s;
            3:       inc = inx & !s;
            default: inc = g;
        endcase
        sig = sig + 128'(inc);
        if (be >= 1) begin
            if (sig == (128'd1 << 24)) begin
                sig = 128'd1 << 23;
                be  = be + 1;
            end
            if (be >= 255) begin
                to_inf = (rm == 0) || (rm == 4) || (rm == 3 && !s) || (rm == 2 && s);
                return to_inf ? {3'b101, s, 31'h7F800000} : {3'b101, s, 31'h7F7FFFFF};
            end
            return {2'b00, inx, s, 8'(be), sig[22:0]};
        end
        return {1'b0, inx, inx, s, sig[30:0]};
    endfunction

    // Random operand with a random leading-one position and a mix of exponent ranges.
    task automatic rand_beat(output logic s, output logic [9:0] e,
                             output logic [48:0] f, output logic [2:0] rm);
        int lp;
        logic [63:0] r;
        logic [48:0] mask;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       e = 10'($urandom_range(100, 154));
            1:       e = 10'($urandom_range(0, 40));
            2:       e = 10'($urandom_range(230, 300));
            default: e = 10'($urandom);
        endcase
        lp   = $urandom_range(0, 48);
        r    = {$urandom, $urandom};
        mask = (49'd1 << lp) - 49'd1;
        if ($urandom_range(0, 7) == 0) f = mask;
        else f = r[48:0] & mask;
        f[lp] = 1'b1;
        if ($urandom_range(0, 15) == 0) f = 49'd0;
        rm = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exponent = 10'd0; in_fraction = 49'd0; in_rounding_mode = 3'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b result=%h flags=%b, expected 0/00000000/000",
                     out_valid, out_result, out_flags);
        end
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [48:0] f;
        logic [2:0]  rm;
        logic [31:0] r;
        logic [2:0]  fl;
    } vec_t;

    task automatic test_directed();
        vec_t v[9];
        v[0] = '{1'b0, 10'd127, 49'h1_0000_0000_0000, 3'd0, 32'h40000000, 3'b000};
        v[1] = '{1'b0, 10'd127, 49'h0_8000_0000_0000, 3'd0, 32'h3F800000, 3'b000};
        v[2] = '{1'b1, 10'd127, 49'h0_0000_0000_0000, 3'd0, 32'h80000000, 3'b000};
        v[3] = '{1'b0, 10'd127, 49'h0_FFFF_FF80_0000, 3'd0, 32'h40000000, 3'b001};
        v[4] = '{1'b0, 10'd127, 49'h0_FFFF_FF80_0000, 3'd1, 32'h3FFFFFFF, 3'b001};
        v[5] = '{1'b0, 10'd255, 49'h0_8000_0000_0000, 3'd0, 32'h7F800000, 3'b101};
        v[6] = '{1'b0, 10'd255, 49'h0_8000_0000_0000, 3'd1, 32'h7F7FFFFF, 3'b101};
`ifdef NORMALIZE_ROUND_SUBNORMAL_EN
        v[7] = '{1'b0, 10'd0,   49'h0_8000_0000_0000, 3'd0, 32'h00400000, 3'b000};
`else
        v[7] = '{1'b0, 10'd0,   49'h0_8000_0000_0000, 3'd0, 32'h00000000, 3'b011};
`endif
        v[8] = '{1'b0, 10'd127, 49'h0_FFFF_FF80_0000, 3'd7, 32'h40000000, 3'b001};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            in_sign = v[i].s; in_exponent = v[i].e; in_fraction = v[i].f; in_rounding_mode = v[i].rm;
            @(negedge clk);
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: out_valid=%b one cycle after accept, expected 0", i, out_valid);
            end
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== v[i].r || out_flags !== v[i].fl) begin
                n_fail++;
                $display("FAIL directed[%0d]: valid=%b result=%h flags=%b, expected 1/%h/%b",
                         i, out_valid, out_result, out_flags, v[i].r, v[i].fl);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic s; logic [9:0] e; logic [48:0] f; logic [2:0] rm;
        logic [34:0] held, exp_v;
        logic stall_prev = 1'b0, saw_block = 1'b0;
        int sent = 0, got = 0;
        sb_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sent < 4) begin
                rand_beat(s, e, f, rm);
                in_valid = 1'b1; in_sign = s; in_exponent = e; in_fraction = f; in_rounding_mode = rm;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(c >= 2 && c < 5);
            #1;
            if (stall_prev) begin
                n_tests++;
                if (out_valid !== 1'b1 || {out_flags, out_result} !== held) begin
                    n_fail++;
                    $display("FAIL b2b_hold: valid=%b out=%h, expected 1/%h", out_valid, {out_flags, out_result}, held);
                end
            end
            n_tests++;
            if (in_ready !== (out_ready || sb_q.size() < 2)) begin
                n_fail++;
                $display("FAIL b2b_in_ready: in_ready=%b, expected %b", in_ready, (out_ready || sb_q.size() < 2));
            end
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious: out=%h, expected no output", {out_flags, out_result});
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({out_flags, out_result} !== exp_v) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: out=%h, expected %h", got, {out_flags, out_result}, exp_v);
                    end
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_flags, out_result};
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_model(in_sign, in_exponent, in_fraction, in_rounding_mode));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 4 || sent != 4 || sb_q.size() != 0 || !saw_block) begin
            n_fail++;
            $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d blocked=%b, expected 4/4/0/1",
                     sent, got, sb_q.size(), saw_block);
        end
    endtask

    task automatic test_random();
        logic s; logic [9:0] e; logic [48:0] f; logic [2:0] rm;
        logic [34:0] held, exp_v;
        logic stall_prev = 1'b0;
        int sent = 0, got = 0;
        sb_q.delete();
        for (int c = 0; c < 4000 && (sent < 400 || sb_q.size() != 0); c++) begin
            @(negedge clk);
            if (sent < 400 && $urandom_range(0, 3) != 0) begin
                rand_beat(s, e, f, rm);
                in_valid = 1'b1; in_sign = s; in_exponent = e; in_fraction = f; in_rounding_mode = rm;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                n_tests++;
                if (out_valid !== 1'b1 || {out_flags, out_result} !== held) begin
                    n_fail++;
                    $display("FAIL rand_hold: valid=%b out=%h, expected 1/%h", out_valid, {out_flags, out_result}, held);
                end
            end
            n_tests++;
            if (in_ready !== (out_ready || sb_q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_in_ready: in_ready=%b, expected %b", in_ready, (out_ready || sb_q.size() < 2));
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: out=%h, expected no output", {out_flags, out_result});
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({out_flags, out_result} !== exp_v) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d]: out=%h, expected %h", got, {out_flags, out_result}, exp_v);
                    end
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_flags, out_result};
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_model(in_sign, in_exponent, in_fraction, in_rounding_mode));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (sent != 400 || got != sent || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: sent=%0d got=%0d pending=%0d, expected 400/400/0", sent, got, sb_q.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        logic s; logic [9:0] e; logic [48:0] f; logic [2:0] rm;
        logic [34:0] exp_v;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rand_beat(s, e, f, rm);
            in_valid = 1'b1; out_ready = 1'b1;
            in_sign = s; in_exponent = e; in_fraction = f; in_rounding_mode = rm;
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: out_valid=%b, expected 1", out_valid);
        end
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 3'b000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b result=%h flags=%b in_ready=%b, expected 0/00000000/000/1",
                     out_valid, out_result, out_flags, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flushed: out_valid=%b, expected 0", out_valid);
        end
        rand_beat(s, e, f, rm);
        in_valid = 1'b1; in_sign = s; in_exponent = e; in_fraction = f; in_rounding_mode = rm;
        exp_v = ref_model(s, e, f, rm);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_latency: out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || {out_flags, out_result} !== exp_v) begin
            n_fail++;
            $display("FAIL midreset_first: valid=%b out=%h, expected 1/%h", out_valid, {out_flags, out_result}, exp_v);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_dup: out_valid=%b after drain, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
